// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared types and constants for the approximate-multiplier controllers
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Iteration counter width; a 1-bit operand still needs one counter bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_approx_mult_if.sv
// rtl/seq_approx_mult_if.sv - operand/product handshake bundle for seq_approx_mult
interface seq_approx_mult_if #(
    parameter int WIDTH = 8
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   approx_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output in_valid, a, b, approx_en, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, approx_en, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/approx_rca.sv
// rtl/approx_rca.sv - ripple-carry adder whose low columns can fall back to carry-free OR cells
module approx_rca
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             mode,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        logic fa_s;
        logic fa_c;

        full_adder u_fa (
            .x    (x[i]),
            .y    (y[i]),
            .cin  (c[i]),
            .s    (fa_s),
            .cout (fa_c)
        );

        if (i < APPROX_COLS) begin : g_approx
            // Approximate columns kill the carry, so the first exact column sees cin=0.
            assign sum[i]  = (mode == MODE_APPROX) ? (x[i] | y[i]) : fa_s;
            assign c[i+1]  = (mode == MODE_APPROX) ? 1'b0 : fa_c;
        end else begin : g_exact
            assign sum[i]  = fa_s;
            assign c[i+1]  = fa_c;
        end
    end
endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit exact full adder cell
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/seq_approx_mult.sv
// rtl/seq_approx_mult.sv - iterative shift-and-add multiplier with optional approximate low columns
module seq_approx_mult
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_approx_mult_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  m;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  p_hi;
    logic [CW-1:0]     cnt;
    logic              fin;
    logic              mode;
    logic [WIDTH-1:0]  rca_sum;
    logic              rca_c;
    logic [WIDTH-1:0]  add_sum;
    logic              add_c;
    logic              in_ready_c;
    logic              out_valid_c;

    approx_rca #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_rca (
        .x    (p_hi),
        .y    (m),
        .mode (mode),
        .sum  (rca_sum),
        .cout (rca_c)
    );

    assign add_sum = q[0] ? rca_sum : p_hi;
    assign add_c   = q[0] ? rca_c   : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (fin) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RUN spends WIDTH cycles iterating plus one settle cycle flagged by fin before DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            m    <= '0;
            q    <= '0;
            p_hi <= '0;
            cnt  <= '0;
            fin  <= 1'b0;
            mode <= MODE_EXACT;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        m    <= bus.a;
                        q    <= bus.b;
                        mode <= bus.approx_en;
                        p_hi <= '0;
                        cnt  <= '0;
                        fin  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!fin) begin
                        p_hi <= {add_c, add_sum[WIDTH-1:1]};
                        q    <= {add_sum[0], q[WIDTH-1:1]};
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) fin <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.product   = out_valid_c ? {p_hi, q} : '0;
endmodule

// File: tb/tb_seq_approx_mult.sv
// tb/tb_seq_approx_mult.sv - directed and random self-checking bench for seq_approx_mult
module tb_seq_approx_mult;
    localparam int W  = 8;
    localparam int AC = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_approx_mult_if #(.WIDTH(W)) bus ();

    seq_approx_mult #(
        .WIDTH       (W),
        .APPROX_COLS (AC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Approximate add: low AC bits OR-combined with no carry out, high bits added exactly.
    function automatic logic [15:0] model(input int a, input int b, input logic mode);
        int mask;
        int p;
        int q;
        int s;
        int full;
        mask = mode ? ((1 << AC) - 1) : 0;
        p = 0;
        q = b;
        for (int i = 0; i < W; i++) begin
            if ((q & 1) != 0)
                s = ((p | a) & mask) + (p & ~mask & 255) + (a & ~mask & 255);
            else
                s = p;
            full = ((s << W) | q) >> 1;
            p = full >> W;
            q = full & 255;
        end
        return 16'((p << W) | q);
    endfunction

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic mode);
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.approx_en = mode;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.a         = 8'($urandom);
        bus.b         = 8'($urandom);
        bus.approx_en = ~mode;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("out_valid_within_budget", bus.out_valid, 1);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic mode,
                          output logic [15:0] prod, output int lat);
        start_op(a, b, mode);
        wait_valid(lat);
        prod = bus.product;
        ack();
    endtask

    initial begin
        logic [15:0] prod;
        int          lat;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rm;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_product", bus.product, 0);
        rst = 1'b0;

        run_op(8'd255, 8'd255, 1'b0, prod, lat);
        check("exact_255x255", prod, 16'hFE01);
        check("latency_255x255", lat, 9);

        run_op(8'd3, 8'd3, 1'b1, prod, lat);
        check("approx_3x3", prod, 7);
        run_op(8'd3, 8'd3, 1'b0, prod, lat);
        check("exact_3x3", prod, 9);

        run_op(8'd0, 8'd200, 1'b0, prod, lat);
        check("exact_0x200", prod, 0);
        run_op(8'd0, 8'd200, 1'b1, prod, lat);
        check("approx_0x200", prod, 0);
        run_op(8'd1, 8'd200, 1'b0, prod, lat);
        check("exact_1x200", prod, 200);
        run_op(8'd1, 8'd200, 1'b1, prod, lat);
        check("approx_1x200", prod, 200);

        // Backpressure with an ignored in_valid pulse while DONE is held.
        start_op(8'd3, 8'd3, 1'b1);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_product", bus.product, 7);
            check("bp_in_ready", bus.in_ready, 0);
            bus.in_valid = (i == 2);
            bus.a        = 8'd9;
            bus.b        = 8'd9;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        ack();
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);
        run_op(8'd5, 8'd6, 1'b0, prod, lat);
        check("after_bp_5x6", prod, 30);
        check("after_bp_latency", lat, 9);

        // Reset during the 4th RUN cycle.
        start_op(8'd200, 8'd100, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrun_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_product", bus.product, 0);
        rst = 1'b0;
        run_op(8'd12, 8'd13, 1'b0, prod, lat);
        check("after_rst_12x13", prod, 156);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'(i % 2);
            run_op(ra, rb, rm, prod, lat);
            if (rm)
                check("random_approx", prod, model(int'(ra), int'(rb), 1'b1));
            else
                check("random_exact", prod, 16'(ra) * 16'(rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
